// File: rtl/fcvt_arb_pkg.sv
// Shared types and the truncating unsigned-to-single converter for fcvt_arb.
package fcvt_arb_pkg;

  localparam int FLOAT_W = 32;
  localparam int INT_W   = 32;
  localparam int RM_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  typedef struct packed {
    logic [INT_W-1:0] data;
    logic [RM_W-1:0]  rm;
    logic             sgn;
  } req_t;

  // Exponent and fraction only; the caller supplies the sign bit.
  function automatic logic [FLOAT_W-2:0] u2f_mag(input logic [INT_W-1:0] u);
    logic [4:0]         lz;
    logic [FLOAT_W-2:0] res;
    lz = '0;
    for (int i = 0; i < INT_W; i++) begin
      if (u[i]) lz = 5'(INT_W - 1 - i);
    end
    if (u == '0) res = '0;
    else         res = {8'd158 - {3'b000, lz}, 23'((u << lz) >> 8)};
    return res;
  endfunction

endpackage

// File: rtl/fcvt_rr_pick.sv
// Combinational round-robin picker: searches from last_grant+1 upward, wrapping.
module fcvt_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  always_comb begin
    logic [IDW-1:0] cand;
    cand      = '0;
    grant_idx = '0;
    any_valid = |req;
    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    for (int off = NREQ; off >= 1; off--) begin
      cand = IDW'((int'(last_grant) + off) % NREQ);
      if (req[cand]) grant_idx = cand;
    end
    grant = '0;
    if (en && any_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/fcvt_arb.sv
// Round-robin sequencer sharing one int-to-single converter among NREQ requesters.
// Optional signed operands are built only when FCVT_ARB_SIGNED_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request; req_ready follows the grant vector
// CONV  | converter output is registered into out_data at the end of this cycle
// DONE  | out_valid high, result held until out_ready; may accept next request
module fcvt_arb
  import fcvt_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][INT_W-1:0] req_data,
  input  logic [NREQ-1:0][RM_W-1:0]  req_rm,
  input  logic [NREQ-1:0]            req_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLOAT_W-1:0]         out_data,
  output logic [IDW-1:0]             out_id,
  output logic                       busy
);

  state_t             state;
  logic [IDW-1:0]     last_grant;
  logic [IDW-1:0]     grant_idx;
  logic [NREQ-1:0]    grant;
  logic               any_valid;
  logic               pick_en;
  logic               accept;
  req_t               sel;
  logic               sel_neg;
  logic [INT_W-1:0]   sel_op;
  logic [INT_W-1:0]   cur_op;
  logic [RM_W-1:0]    cur_rm;
  logic               cur_neg;
  logic [IDW-1:0]     cur_id;
  logic [FLOAT_W-1:0] conv_res;
  logic               unused_rm;

  assign pick_en = (state == IDLE) || ((state == DONE) && out_ready);

  fcvt_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         (pick_en),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_valid  (any_valid)
  );

  assign req_ready = grant;
  assign accept    = pick_en && any_valid;
  assign busy      = (state != IDLE);

  assign sel = {req_data[grant_idx], req_rm[grant_idx], req_signed[grant_idx]};

`ifdef FCVT_ARB_SIGNED_EN
  assign sel_neg = sel.sgn & sel.data[INT_W-1];
  assign sel_op  = sel_neg ? -sel.data : sel.data;
`else
  logic unused_sgn;
  assign unused_sgn = sel.sgn;
  assign sel_neg    = 1'b0;
  assign sel_op     = sel.data;
`endif

  // The converter truncates, so rm is carried along but does not alter the result.
  assign conv_res  = {cur_neg, u2f_mag(cur_op)};
  assign unused_rm = ^cur_rm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      cur_op     <= '0;
      cur_rm     <= '0;
      cur_neg    <= 1'b0;
      cur_id     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
    end else begin
      if (accept) begin
        cur_op     <= sel_op;
        cur_rm     <= sel.rm;
        cur_neg    <= sel_neg;
        cur_id     <= grant_idx;
        last_grant <= grant_idx;
      end
      case (state)
        IDLE: begin
          if (accept) state <= CONV;
        end
        CONV: begin
          out_data  <= conv_res;
          out_id    <= cur_id;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? CONV : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcvt_arb.sv
// Self-checking bench for fcvt_arb: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_fcvt_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

`ifdef FCVT_ARB_SIGNED_EN
  localparam logic [31:0] EXP_NEG_ONE = 32'hBF800000;
`else
  localparam logic [31:0] EXP_NEG_ONE = 32'h4F7FFFFF;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_data;
  logic [NREQ-1:0][2:0]  req_rm;
  logic [NREQ-1:0]       req_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_data;
  logic [IDW-1:0]        out_id;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int model_last = NREQ - 1;

  typedef struct {
    int          id;
    logic [31:0] d;
  } exp_t;

  fcvt_arb #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_rm     (req_rm),
    .req_signed (req_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  // Reference conversion from value arithmetic: 2^e * (1 + f/2^23), truncated.
  function automatic logic [31:0] ref_conv(input logic [31:0] v, input logic sgn);
    logic   neg;
    longint mag;
    longint frac;
    int     msb;
`ifdef FCVT_ARB_SIGNED_EN
    neg = sgn && v[31];
`else
    neg = 1'b0;
    if (sgn) neg = 1'b0;
`endif
    mag = neg ? (longint'(64'h1_0000_0000) - longint'(v)) : longint'(v);
    if (mag == 0) return 32'h0;
    msb = 0;
    while ((longint'(1) << (msb + 1)) <= mag) msb++;
    frac = ((mag - (longint'(1) << msb)) * (longint'(1) << 23)) / (longint'(1) << msb);
    return {neg, 8'(127 + msb), 23'(frac)};
  endfunction

  function automatic int ref_pick(input int last, input logic [NREQ-1:0] v);
    for (int off = 1; off <= NREQ; off++) begin
      if (v[(last + off) % NREQ]) return (last + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = NREQ - 1;
  endtask

  // One isolated request; lat = -2 never accepted, -1 no result, else cycles after accept.
  task automatic do_one(input int idx, input logic [31:0] d, input logic sgn,
                        output logic [31:0] got_d, output int got_id, output int lat);
    got_d  = '0;
    got_id = -1;
    lat    = -2;
    @(negedge clk);
    req_valid        = '0;
    req_valid[idx]   = 1'b1;
    req_data[idx]    = d;
    req_signed[idx]  = sgn;
    req_rm[idx]      = 3'($urandom);
    out_ready        = 1'b1;
    for (int k = 0; k < 10 && lat == -2; k++) begin
      #1;
      if (req_ready[idx]) lat = -1;
      @(negedge clk);
    end
    req_valid = '0;
    if (lat == -1) model_last = idx;
    for (int k = 1; k < 10 && lat == -1; k++) begin
      #1;
      if (out_valid) begin
        lat    = k;
        got_d  = out_data;
        got_id = int'(out_id);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_rm     = '0;
    req_signed = '0;
    out_ready  = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
    checks++; if (out_id !== '0) begin errors++; $display("FAIL reset_out_id got %0d want 0", out_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = NREQ - 1;
  endtask

  task automatic test_single();
    logic [31:0] d;
    int id, lat;
    do_one(0, 32'd1, 1'b0, d, id, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", lat); end
    checks++; if (d !== 32'h3F800000) begin errors++; $display("FAIL single_data got %h want 3f800000", d); end
    checks++; if (id !== 0) begin errors++; $display("FAIL single_id got %0d want 0", id); end
  endtask

  task automatic test_zero_topbit();
    logic [31:0] d;
    int id, lat;
    do_one(2, 32'h0, 1'b0, d, id, lat);
    checks++; if (d !== 32'h0 || lat !== 2) begin errors++; $display("FAIL zero_data got %h lat %0d want 00000000 lat 2", d, lat); end
    do_one(1, 32'h80000000, 1'b0, d, id, lat);
    checks++; if (d !== 32'h4F000000 || id !== 1) begin errors++; $display("FAIL topbit_data got %h id %0d want 4f000000 id 1", d, id); end
`ifdef FCVT_ARB_SIGNED_EN
    do_one(3, 32'h80000000, 1'b1, d, id, lat);
    checks++; if (d !== 32'hCF000000) begin errors++; $display("FAIL topbit_signed got %h want cf000000", d); end
`endif
  endtask

  task automatic test_signed();
    logic [31:0] d;
    int id, lat;
    do_one(3, 32'hFFFFFFFF, 1'b1, d, id, lat);
    checks++; if (d !== EXP_NEG_ONE || id !== 3) begin errors++; $display("FAIL signed_neg_one got %h id %0d want %h id 3", d, id, EXP_NEG_ONE); end
  endtask

  task automatic test_round_robin();
    int gseq[$];
    int gcyc[$];
    int nres;
    int g;
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_data[i]   = 32'd5;
      req_signed[i] = 1'b0;
    end
    req_valid = '1;
    out_ready = 1'b1;
    nres = 0;
    for (int c = 0; c < 30 && gseq.size() < 5; c++) begin
      #1;
      if (out_valid) begin
        checks++; if (out_data !== 32'h40A00000) begin errors++; $display("FAIL rr_data result %0d got %h want 40a00000", nres, out_data); end
        checks++; if (nres >= gseq.size() || int'(out_id) !== gseq[nres]) begin errors++; $display("FAIL rr_out_id result %0d got %0d want %0d", nres, out_id, nres % NREQ); end
        nres++;
      end
      if (req_ready != '0) begin
        checks++; if (!$onehot(req_ready)) begin errors++; $display("FAIL rr_onehot got %b want one-hot", req_ready); end
        g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        gseq.push_back(g);
        gcyc.push_back(c);
      end
      @(negedge clk);
    end
    req_valid = '0;
    checks++; if (gseq.size() !== 5) begin errors++; $display("FAIL rr_grant_count got %0d want 5", gseq.size()); end
    if (gseq.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (gseq[i] !== i % NREQ) begin errors++; $display("FAIL rr_order grant %0d got %0d want %0d", i, gseq[i], i % NREQ); end
      end
      for (int i = 1; i < 5; i++) begin
        checks++; if (gcyc[i] - gcyc[i-1] !== 2) begin errors++; $display("FAIL rr_spacing grant %0d got %0d want 2", i, gcyc[i] - gcyc[i-1]); end
      end
    end
    checks++; if (nres < 4) begin errors++; $display("FAIL rr_results got %0d want 4", nres); end
    model_last = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] e7, e9;
    int n;
    e7 = ref_conv(32'd7, 1'b0);
    e9 = ref_conv(32'd9, 1'b0);
    @(negedge clk);
    req_valid     = 4'b0100;
    req_data[2]   = 32'd7;
    req_signed[2] = 1'b0;
    out_ready     = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_accept got %b want 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    req_valid     = 4'b0010;
    req_data[1]   = 32'd9;
    req_signed[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== e7 || out_id !== 2'd2 || req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%0b d=%h id=%0d rdy=%b want v=1 d=%h id=2 rdy=0000",
                 k, out_valid, out_data, out_id, req_ready, e7);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_fast got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    n = 0;
    for (int k = 0; k < 6 && !out_valid; k++) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++; if (out_valid !== 1'b1 || out_data !== e9 || out_id !== 2'd1 || n !== 1) begin
      errors++;
      $display("FAIL bp_next got v=%0b d=%h id=%0d wait=%0d want v=1 d=%h id=1 wait=1", out_valid, out_data, out_id, n, e9);
    end
    model_last = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid     = 4'b0100;
    req_data[2]   = 32'd12;
    req_signed[2] = 1'b0;
    out_ready     = 1'b1;
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0 || out_id !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got v=%0b busy=%0b d=%h id=%0d rdy=%b want all zero",
               out_valid, busy, out_data, out_id, req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_data[i]   = 32'd3;
      req_signed[i] = 1'b0;
    end
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== ref_conv(32'd3, 1'b0)) begin
      errors++;
      $display("FAIL mid_after_result got v=%0b id=%0d d=%h want v=1 id=0 d=%h", out_valid, out_id, out_data, ref_conv(32'd3, 1'b0));
    end
    model_last = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    exp_t            q[$];
    exp_t            e;
    logic [NREQ-1:0] acc;
    logic            pop;
    logic            expect_ready;
    int              g;
    logic [31:0]     d;
    apply_reset();
    acc = '0;
    for (int n = 0; n < 320; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (n < 300 && !req_valid[i] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 4))
            0:       d = 32'h0;
            1:       d = 32'h80000000;
            2:       d = 32'hFFFFFFFF;
            3:       d = 32'($urandom_range(0, 255));
            default: d = $urandom;
          endcase
          req_data[i]   = d;
          req_rm[i]     = 3'($urandom);
          req_signed[i] = 1'($urandom);
          req_valid[i]  = 1'b1;
        end
      end
      out_ready = (n >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      pop          = out_valid && out_ready;
      expect_ready = (|req_valid) && (q.size() == 0 || pop);
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious_result got id=%0d d=%h want no result", out_id, out_data);
        end else if (int'(out_id) !== q[0].id || out_data !== q[0].d) begin
          errors++;
          $display("FAIL rand_result got id=%0d d=%h want id=%0d d=%h", out_id, out_data, q[0].id, q[0].d);
        end
      end
      if (pop && q.size() > 0) void'(q.pop_front());
      checks++;
      if ((req_ready != '0) !== expect_ready) begin
        errors++;
        $display("FAIL rand_ready_state cycle %0d got %b want ready=%0b", n, req_ready, expect_ready);
      end
      if (req_ready != '0) begin
        g = ref_pick(model_last, req_valid);
        checks++;
        if (g < 0 || req_ready !== (NREQ'(1) << g)) begin
          errors++;
          $display("FAIL rand_grant cycle %0d got %b want requester %0d", n, req_ready, g);
        end
        if (g >= 0) begin
          e.id = g;
          e.d  = ref_conv(req_data[g], req_signed[g]);
          q.push_back(e);
          model_last = g;
        end
      end
      acc = req_ready & req_valid;
    end
    req_valid = '0;
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL rand_drain got %0d outstanding want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_topbit();
    test_signed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
